// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and
// the parity helper used by both ends of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Parity bit the transmitter appends: even parity when sel = 0, odd when sel = 1.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic sel);
    return (^data) ^ sel;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver.
// master = the side driving the line (pad / test source), slave = the receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx_in;
  logic                 p_sel;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx_in, p_sel,
    input  rx_data, rx_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  rx_in, p_sel,
    output rx_data, rx_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous input that idles high.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the async input through the chain; reset to the idle (high) level.
  always_ff @(posedge clk) begin
    if (reset) r_chain <= '1;
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start + 8 data (LSB first) + parity + stop, mid-bit sampled.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 w_rx_s;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_rx_prev;
  logic                 r_perr_pend;
  logic                 r_stop_smp;
  logic                 r_fin;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_perr;
  logic                 r_ferr;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.rx_in),
    .o_q   (w_rx_s)
  );

  // Previous synchronized level, for 1->0 start-edge detection.
  always_ff @(posedge clk) begin
    if (reset) r_rx_prev <= 1'b1;
    else       r_rx_prev <= w_rx_s;
  end

  // Staging register for data bits; kept apart from rx_data so the output holds mid-frame.
  always_ff @(posedge clk) begin
    if (r_state == DATA && r_cnt == FULL_M1) r_shift[r_bit_idx] <= w_rx_s;
  end

  // Frame FSM: sample at bit centres and deliver the byte one clock after the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_perr_pend <= 1'b0;
      r_stop_smp  <= 1'b1;
      r_fin       <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (r_rx_prev && !w_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (r_bit_idx == LAST_BIT) r_state   <= PARITY;
            else                       r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (r_cnt == FULL_M1) begin
            r_cnt       <= '0;
            r_perr_pend <= (w_rx_s != parity_bit(r_shift, bus.p_sel));
            r_state     <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_fin) begin
            r_fin      <= 1'b0;
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_shift;
            r_perr     <= r_perr_pend;
            r_ferr     <= !r_stop_smp;
            r_state    <= IDLE;
          end else if (r_cnt == FULL_M1) begin
            r_cnt      <= '0;
            r_stop_smp <= w_rx_s;
            r_fin      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data    = r_rx_data;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// break, glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk;
  logic reset;
  uart_rx_if u_if();

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Cycle counter and rx_valid capture (sampled on the falling edge).
  int         cyc = 0;
  int         valid_cnt = 0;
  logic [7:0] cap_data [0:31];
  logic       cap_perr [0:31];
  logic       cap_ferr [0:31];
  int         cap_cyc  [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.rx_valid === 1'b1) begin
      if (valid_cnt < 32) begin
        cap_data[valid_cnt] = u_if.rx_data;
        cap_perr[valid_cnt] = u_if.parity_err;
        cap_ferr[valid_cnt] = u_if.frame_err;
        cap_cyc[valid_cnt]  = cyc;
      end
      valid_cnt = valid_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  task automatic send_bit(input logic b);
    u_if.rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pb);
    send_bit(sb);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       psel;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    int base;
    logic [7:0] held;

    // data, p_sel, parity bit sent, stop bit, expected data/perr/ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'hE7, 1'b0, 1'b0, 1'b0, 8'hE7, 1'b0, 1'b1};

    reset     = 1'b1;
    u_if.rx_in = 1'b1;
    u_if.p_sel = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset.rx_data",    {24'd0, u_if.rx_data}, 32'h00);
    chk("reset.rx_valid",   {31'd0, u_if.rx_valid}, 32'd0);
    chk("reset.parity_err", {31'd0, u_if.parity_err}, 32'd0);
    chk("reset.frame_err",  {31'd0, u_if.frame_err}, 32'd0);
    chk("reset.busy",       {31'd0, u_if.busy}, 32'd0);
    reset = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;

    // Table-driven single frames.
    for (int v = 0; v < 6; v++) begin
      base = valid_cnt;
      u_if.p_sel = vecs[v].psel;
      send_frame(vecs[v].data, vecs[v].pbit, vecs[v].stop);
      send_bit(1'b1);
      send_bit(1'b1);
      chk($sformatf("vec%0d.strobes", v), valid_cnt - base, 1);
      chk($sformatf("vec%0d.data", v), {24'd0, cap_data[base]}, {24'd0, vecs[v].exp_data});
      chk($sformatf("vec%0d.perr", v), {31'd0, cap_perr[base]}, {31'd0, vecs[v].exp_perr});
      chk($sformatf("vec%0d.ferr", v), {31'd0, cap_ferr[base]}, {31'd0, vecs[v].exp_ferr});
      chk($sformatf("vec%0d.held", v), {24'd0, u_if.rx_data}, {24'd0, vecs[v].exp_data});
    end

    // Framing error followed by a 40-bit break, then recovery.
    u_if.p_sel = 1'b0;
    base = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    chk("break.strobes", valid_cnt - base, 1);
    chk("break.ferr", {31'd0, cap_ferr[base]}, 32'd1);
    chk("break.data", {24'd0, cap_data[base]}, 32'h55);
    chk("break.busy_idle", {31'd0, u_if.busy}, 32'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("break.release_strobes", valid_cnt - base, 1);
    send_frame(8'h0F, 1'b0, 1'b1);
    send_bit(1'b1);
    chk("recover.strobes", valid_cnt - base, 2);
    chk("recover.data", {24'd0, cap_data[base+1]}, 32'h0F);
    chk("recover.ferr", {31'd0, cap_ferr[base+1]}, 32'd0);

    // Glitch: 5 low clocks must be rejected at the start-bit centre.
    base = valid_cnt;
    held = u_if.rx_data;
    u_if.rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("glitch.busy_high", {31'd0, u_if.busy}, 32'd1);
    u_if.rx_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("glitch.busy_low", {31'd0, u_if.busy}, 32'd0);
    repeat (3 * CPB) @(posedge clk);
    #1;
    chk("glitch.strobes", valid_cnt - base, 0);
    chk("glitch.data_held", {24'd0, u_if.rx_data}, {24'd0, held});

    // Back-to-back frames with no idle gap.
    base = valid_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("b2b.strobes", valid_cnt - base, 3);
    chk("b2b.data0", {24'd0, cap_data[base]},   32'h00);
    chk("b2b.data1", {24'd0, cap_data[base+1]}, 32'hFF);
    chk("b2b.data2", {24'd0, cap_data[base+2]}, 32'h81);
    chk("b2b.gap01", cap_cyc[base+1] - cap_cyc[base],   176);
    chk("b2b.gap12", cap_cyc[base+2] - cap_cyc[base+1], 176);
    chk("b2b.errs", {30'd0, cap_perr[base+2], cap_ferr[base+2]}, 32'd0);

    // Reset in the middle of data bit 4 of 0xC3.
    base = valid_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'((8'hC3 >> i) & 8'h01));
    u_if.rx_in = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset      = 1'b1;
    u_if.rx_in = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.rx_data",    {24'd0, u_if.rx_data}, 32'h00);
    chk("midrst.rx_valid",   {31'd0, u_if.rx_valid}, 32'd0);
    chk("midrst.parity_err", {31'd0, u_if.parity_err}, 32'd0);
    chk("midrst.frame_err",  {31'd0, u_if.frame_err}, 32'd0);
    chk("midrst.busy",       {31'd0, u_if.busy}, 32'd0);
    reset = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #1;
    chk("midrst.strobes", valid_cnt - base, 0);
    send_frame(8'h12, 1'b0, 1'b1);
    send_bit(1'b1);
    chk("after_rst.strobes", valid_cnt - base, 1);
    chk("after_rst.data", {24'd0, cap_data[base]}, 32'h12);
    chk("after_rst.errs", {30'd0, cap_perr[base], cap_ferr[base]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
